// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and types for the register-file write-port controller.
// Pure definitions: no latency, no flow control.
package rf_write_arbiter_pkg;

  localparam int WORD_SIZE  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  typedef logic [REG_ADDR_W-1:0] reg_num_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Writeback request ports and register-file write port, bundled together.
// The slave side is the arbiter; the master side is the writeback stage / register file.
interface rf_write_arbiter_if import rf_write_arbiter_pkg::*; #(
  parameter int WORD_SIZE = 32
);

  logic                 i_req0;
  reg_num_t             i_num0;
  logic [WORD_SIZE-1:0] i_data0;
  logic                 o_gnt0;

  logic                 i_req1;
  reg_num_t             i_num1;
  logic [WORD_SIZE-1:0] i_data1;
  logic                 o_gnt1;

  logic                 o_Wen;
  reg_num_t             o_Wnum;
  logic [WORD_SIZE-1:0] o_Wd;
  logic                 o_busy;

  modport slave (
    input  i_req0, i_num0, i_data0,
    input  i_req1, i_num1, i_data1,
    output o_gnt0, o_gnt1,
    output o_Wen, o_Wnum, o_Wd, o_busy
  );

  modport master (
    output i_req0, i_num0, i_data0,
    output i_req1, i_num1, i_data1,
    input  o_gnt0, o_gnt1,
    input  o_Wen, o_Wnum, o_Wd, o_busy
  );

endinterface

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; grant is combinational (zero latency).
// No grant while advance is low; the pointer flips to the other port on every grant.
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr;  // 1 = port 1 preferred on contention

  always_comb begin
    gnt = 2'b00;
    if (advance) begin
      if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     ptr <= 1'b0;
    else if (|gnt) ptr <= gnt[0];
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between two writeback ports and zero-fills x1..x31 after reset.
// Grant in cycle N, write visible in N+1; requests hold while busy or while losing arbitration.
module rf_write_arbiter import rf_write_arbiter_pkg::*; #(
  parameter int WORD_SIZE      = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  rf_write_arbiter_if.slave  bus
);

  typedef struct packed {
    reg_num_t             num;
    logic [WORD_SIZE-1:0] data;
  } wr_t;

  localparam state_t RST_STATE = CLEAR_ON_RESET ? ST_INIT : ST_RUN;

  state_t               state, state_nxt;
  reg_num_t             clr_cnt, clr_cnt_nxt;
  logic                 wen_q, wen_nxt;
  reg_num_t             wnum_q, wnum_nxt;
  logic [WORD_SIZE-1:0] wd_q, wd_nxt;
  logic                 busy_q, busy_nxt;
  logic [1:0]           req, gnt;
  logic                 run;
  wr_t                  sel;

  assign run = (state == ST_RUN);
  assign req = {bus.i_req1, bus.i_req0};

  rr_arb2 u_arb (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .req     (req),
    .advance (run),
    .gnt     (gnt)
  );

  assign bus.o_gnt0 = gnt[0];
  assign bus.o_gnt1 = gnt[1];

  always_comb begin
    sel.num  = bus.i_num0;
    sel.data = bus.i_data0;
    if (gnt[1]) begin
      sel.num  = bus.i_num1;
      sel.data = bus.i_data1;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    wen_nxt     = 1'b0;
    wnum_nxt    = wnum_q;
    wd_nxt      = wd_q;
    busy_nxt    = 1'b0;
    case (state)
      ST_INIT: begin
        wen_nxt     = 1'b1;
        wnum_nxt    = clr_cnt;
        wd_nxt      = '0;
        clr_cnt_nxt = clr_cnt + 1'b1;
        // busy drops on the same edge that issues the x31 clear write
        if (clr_cnt == reg_num_t'(REG_COUNT - 1)) state_nxt = ST_RUN;
        else                                      busy_nxt  = 1'b1;
      end
      ST_RUN: begin
        if (|gnt) begin
          wen_nxt  = (sel.num != '0);
          wnum_nxt = sel.num;
          wd_nxt   = sel.data;
        end
      end
      default: state_nxt = RST_STATE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= RST_STATE;
      clr_cnt <= reg_num_t'(1);
      wen_q   <= 1'b0;
      wnum_q  <= '0;
      wd_q    <= '0;
      busy_q  <= CLEAR_ON_RESET;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      wen_q   <= wen_nxt;
      wnum_q  <= wnum_nxt;
      wd_q    <= wd_nxt;
      busy_q  <= busy_nxt;
    end
  end

  assign bus.o_Wen  = wen_q;
  assign bus.o_Wnum = wnum_q;
  assign bus.o_Wd   = wd_q;
  assign bus.o_busy = busy_q;

endmodule
